// File: rtl/cp_remover.sv
// cp_remover: strips the cyclic prefix from every OFDM symbol of a
// synchronizer frame and forwards only the nfft+1 data samples per symbol
// to the receive FFT. Full AXI-Stream backpressure, one output register stage.
//
// Ports:
//   axis_aclk, axis_rst          clock, asynchronous active-high reset
//   s_axis_*                     frame samples from the synchronizer
//   m_axis_*                     CP-stripped samples; tlast = last sample of
//                                each symbol, tuser = symbol 0 sample 0
//   i_nfft, i_cp_len, i_symbols  frame geometry, latched on a frame's first beat
//   o_frame_err                  1-cycle pulse on input tlast / frame length mismatch
//   o_frame_cnt, o_err_cnt       frame statistics
//
// Optional feature: define CP_REMOVER_STATS_EN to make o_frame_cnt/o_err_cnt
// live saturating counters; otherwise both are tied to zero.
module cp_remover #(
  parameter  int unsigned g_DATA_W = 32,
  localparam int unsigned KEEP_W   = g_DATA_W / 8,
  localparam int unsigned NFFT_W   = 14,
  localparam int unsigned CP_W     = 12,
  localparam int unsigned SYM_W    = 4,
  localparam int unsigned CNT_W    = 16
) (
  input  logic                axis_aclk,
  input  logic                axis_rst,
  input  logic [g_DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [g_DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [KEEP_W-1:0]   m_axis_tkeep,
  input  logic                m_axis_tready,
  input  logic [NFFT_W-1:0]   i_nfft,
  input  logic [CP_W-1:0]     i_cp_len,
  input  logic [SYM_W-1:0]    i_symbols,
  output logic                o_frame_err,
  output logic [CNT_W-1:0]    o_frame_cnt,
  output logic [CNT_W-1:0]    o_err_cnt
);

  typedef enum logic [1:0] {IDLE, CP, DATA, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NFFT_W-1:0]  nfft_q, cfg_nfft, sample_cnt_q, sample_cnt_d, cur_sample;
  logic [CP_W-1:0]    cp_len_q, cfg_cp, cp_cnt_q, cp_cnt_d;
  logic [SYM_W-1:0]   symbols_q, cfg_sym, sym_cnt_q, sym_cnt_d, cur_sym;
  logic               run_q, accept, data_beat;
  logic               fwd, fwd_last, fwd_user, frame_err_d, frame_done;

  // run_q keeps the input stalled while in reset and for the first edge after it
  assign s_axis_tready = run_q & (~m_axis_tvalid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // The first beat of a frame is decoded with the live config; later beats
  // use the copy latched on that first beat.
  assign cfg_nfft   = (state_q == IDLE) ? i_nfft    : nfft_q;
  assign cfg_cp     = (state_q == IDLE) ? i_cp_len  : cp_len_q;
  assign cfg_sym    = (state_q == IDLE) ? i_symbols : symbols_q;
  assign cur_sample = (state_q == IDLE) ? '0 : sample_cnt_q;
  assign cur_sym    = (state_q == IDLE) ? '0 : sym_cnt_q;

  // Next-state / beat classification
  always_comb begin
    state_d      = state_q;
    cp_cnt_d     = cp_cnt_q;
    sample_cnt_d = sample_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    data_beat    = 1'b0;
    fwd          = 1'b0;
    fwd_last     = 1'b0;
    fwd_user     = 1'b0;
    frame_err_d  = 1'b0;
    frame_done   = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: begin
          sample_cnt_d = '0;
          sym_cnt_d    = '0;
          if (cfg_cp == '0) begin
            data_beat = 1'b1;
          end else if (s_axis_tlast) begin
            frame_err_d = 1'b1;
          end else if (cfg_cp == CP_W'(1)) begin
            state_d = DATA;
          end else begin
            // this beat is CP sample 0
            state_d  = CP;
            cp_cnt_d = CP_W'(1);
          end
        end
        CP: begin
          if (s_axis_tlast) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (cp_cnt_q == cfg_cp - CP_W'(1)) begin
            state_d = DATA;
          end else begin
            cp_cnt_d = cp_cnt_q + CP_W'(1);
          end
        end
        DATA:  data_beat = 1'b1;
        DRAIN: if (s_axis_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (data_beat) begin
        fwd      = 1'b1;
        fwd_user = (cur_sample == '0) && (cur_sym == '0);
        if (cur_sample == cfg_nfft) begin
          fwd_last     = 1'b1;
          sample_cnt_d = '0;
          if (cur_sym == cfg_sym) begin
            // final sample of the frame: input tlast must coincide
            if (s_axis_tlast) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (s_axis_tlast) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            sym_cnt_d = cur_sym + SYM_W'(1);
            cp_cnt_d  = '0;
            state_d   = (cfg_cp == '0) ? DATA : CP;
          end
        end else if (s_axis_tlast) begin
          fwd_last    = 1'b1;
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          sample_cnt_d = cur_sample + NFFT_W'(1);
          state_d      = DATA;
        end
      end
    end
  end

  // State register
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Counters and latched frame config
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      run_q        <= 1'b0;
      cp_cnt_q     <= '0;
      sample_cnt_q <= '0;
      sym_cnt_q    <= '0;
      nfft_q       <= '0;
      cp_len_q     <= '0;
      symbols_q    <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      cp_cnt_q     <= cp_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      o_frame_err  <= frame_err_d;
      if (accept && (state_q == IDLE)) begin
        nfft_q    <= i_nfft;
        cp_len_q  <= i_cp_len;
        symbols_q <= i_symbols;
      end
    end
  end

  // Output register stage; holds while the FFT stalls
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tkeep  <= '0;
    end else if (fwd) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= fwd_last;
      m_axis_tuser  <= fwd_user;
      m_axis_tkeep  <= '1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tkeep  <= '0;
    end
  end

`ifdef CP_REMOVER_STATS_EN
  // Saturating frame statistics
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      if (frame_done && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
      if (frame_err_d && (o_err_cnt != '1))  o_err_cnt   <= o_err_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_done;
  assign o_frame_cnt  = '0;
  assign o_err_cnt    = '0;
`endif

endmodule
